// File: rtl/regfile_port_ctrl_pkg.sv
// Shared encodings for the register-file port controller: FSM states,
// debug slot phases and the wait counter width helper.
package regfile_port_ctrl_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } fsm_t;

   typedef enum logic [1:0] {
      EMPTY    = 2'd0,
      WR_WAIT  = 2'd1,
      RD_ISSUE = 2'd2,
      RD_RESP  = 2'd3
   } phase_t;

   // wait_cnt must be able to hold the value STARVE_LIMIT itself
   function automatic int wait_cnt_w(input int limit);
      return $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/regfile_port_ctrl.sv
// Owns the register file write port and read port 1: post-reset clear,
// core writeback forwarding, and a one-entry debug slot with starvation guard.
module regfile_port_ctrl
   import regfile_port_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 5,
   parameter int REG_COUNT    = 32,
   parameter int STARVE_LIMIT = 4
)(
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  WB_EN,
   input  logic [ADDR_WIDTH-1:0] WB_ADDR,
   input  logic [DATA_WIDTH-1:0] WB_DATA,
   input  logic [ADDR_WIDTH-1:0] CORE_A1,
   output logic                  CORE_STALL,
   output logic                  INIT_DONE,
   input  logic                  DBG_VALID,
   input  logic                  DBG_WE,
   input  logic [ADDR_WIDTH-1:0] DBG_ADDR,
   input  logic [DATA_WIDTH-1:0] DBG_WDATA,
   output logic                  DBG_READY,
   output logic [DATA_WIDTH-1:0] DBG_RDATA,
   output logic                  DBG_RVALID,
   output logic                  RF_WE3,
   output logic [ADDR_WIDTH-1:0] RF_A3,
   output logic [DATA_WIDTH-1:0] RF_WD3,
   output logic [ADDR_WIDTH-1:0] RF_A1,
   input  logic [DATA_WIDTH-1:0] RF_RD1
);

   localparam int WCW = wait_cnt_w(STARVE_LIMIT);

   fsm_t                  state;
   phase_t                phase;
   logic [ADDR_WIDTH-1:0] init_cnt;
   logic [WCW-1:0]        wait_cnt;
   logic [ADDR_WIDTH-1:0] slot_addr;
   logic [DATA_WIDTH-1:0] slot_wdata;

   logic pending, starve, drain, accept;

   assign pending   = (phase != EMPTY);
   assign DBG_READY = INIT_DONE && !pending;
   assign accept    = DBG_VALID && DBG_READY;
   assign starve    = (phase == WR_WAIT) && (wait_cnt == WCW'(STARVE_LIMIT));
   // the slot takes the write port whenever the core leaves it idle
   assign drain     = (phase == WR_WAIT) && (!WB_EN || starve);

   // stall depends only on registered state, never on WB_*
   assign CORE_STALL = (state == INIT) || (phase == RD_ISSUE) || starve;

   always_comb begin
      RF_WE3 = 1'b0;
      RF_A3  = WB_ADDR;
      RF_WD3 = WB_DATA;
      RF_A1  = CORE_A1;
      if (state == INIT) begin
         RF_WE3 = 1'b1;
         RF_A3  = init_cnt;
         RF_WD3 = '0;
      end else if (drain) begin
         RF_WE3 = 1'b1;
         RF_A3  = slot_addr;
         RF_WD3 = slot_wdata;
      end else if (phase == RD_ISSUE) begin
         RF_A1  = slot_addr;
      end else begin
         RF_WE3 = WB_EN;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state      <= INIT;
         phase      <= EMPTY;
         init_cnt   <= '0;
         wait_cnt   <= '0;
         slot_addr  <= '0;
         slot_wdata <= '0;
         INIT_DONE  <= 1'b0;
         DBG_RDATA  <= '0;
         DBG_RVALID <= 1'b0;
      end else begin
         DBG_RVALID <= 1'b0;
         if (state == INIT) begin
            init_cnt <= init_cnt + ADDR_WIDTH'(1);
            if (init_cnt == ADDR_WIDTH'(REG_COUNT - 1)) begin
               state     <= RUN;
               INIT_DONE <= 1'b1;
            end
         end else begin
            case (phase)
               EMPTY: begin
                  if (accept) begin
                     slot_addr  <= DBG_ADDR;
                     slot_wdata <= DBG_WDATA;
                     wait_cnt   <= '0;
                     phase      <= DBG_WE ? WR_WAIT : RD_ISSUE;
                  end
               end
               WR_WAIT: begin
                  if (drain) begin
                     phase    <= EMPTY;
                     wait_cnt <= '0;
                  end else begin
                     wait_cnt <= wait_cnt + WCW'(1);
                  end
               end
               // slot frees in the response cycle so READY and RVALID coincide
               RD_ISSUE: begin
                  DBG_RDATA  <= RF_RD1;
                  DBG_RVALID <= 1'b1;
                  phase      <= EMPTY;
               end
               default: phase <= EMPTY;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Scoreboard bench for regfile_port_ctrl: a behavioural register file hangs
// off the RF_* port; expected writes and read responses are queued by stimulus.
module tb_regfile_port_ctrl;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        WB_EN;
   logic [4:0]  WB_ADDR;
   logic [31:0] WB_DATA;
   logic [4:0]  CORE_A1;
   logic        CORE_STALL, INIT_DONE;
   logic        DBG_VALID, DBG_WE;
   logic [4:0]  DBG_ADDR;
   logic [31:0] DBG_WDATA;
   logic        DBG_READY, DBG_RVALID;
   logic [31:0] DBG_RDATA;
   logic        RF_WE3;
   logic [4:0]  RF_A3, RF_A1;
   logic [31:0] RF_WD3, RF_RD1;

   regfile_port_ctrl #(
      .DATA_WIDTH(32), .ADDR_WIDTH(5), .REG_COUNT(32), .STARVE_LIMIT(4)
   ) dut (
      .CLK(CLK), .RST_N(RST_N),
      .WB_EN(WB_EN), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
      .CORE_A1(CORE_A1), .CORE_STALL(CORE_STALL), .INIT_DONE(INIT_DONE),
      .DBG_VALID(DBG_VALID), .DBG_WE(DBG_WE), .DBG_ADDR(DBG_ADDR),
      .DBG_WDATA(DBG_WDATA), .DBG_READY(DBG_READY), .DBG_RDATA(DBG_RDATA),
      .DBG_RVALID(DBG_RVALID),
      .RF_WE3(RF_WE3), .RF_A3(RF_A3), .RF_WD3(RF_WD3), .RF_A1(RF_A1),
      .RF_RD1(RF_RD1)
   );

   always #5 CLK = ~CLK;

   // register file model: x0 reads as zero, preloaded with junk
   logic [31:0] rf [32];
   logic        preload = 1'b1;
   always @(posedge CLK) begin
      if (preload) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'hBAD0_0000 | i;
      end else if (RF_WE3 && RF_A3 != 5'd0) begin
         rf[RF_A3] <= RF_WD3;
      end
   end
   assign RF_RD1 = (RF_A1 == 5'd0) ? 32'd0 : rf[RF_A1];

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   wr_t         wq[$];
   logic [31:0] rq[$];
   int          total = 0;
   int          bad   = 0;

   always @(negedge CLK) begin
      if (RST_N) begin
         if (RF_WE3) begin
            total++;
            if (wq.size() == 0) begin
               bad++;
               $display("FAIL write_unexpected: got a3=%0d wd3=%h, none required", RF_A3, RF_WD3);
            end else begin
               wr_t e;
               e = wq.pop_front();
               if (e.a != RF_A3 || e.d != RF_WD3) begin
                  bad++;
                  $display("FAIL write: got a3=%0d wd3=%h, required a3=%0d wd3=%h",
                           RF_A3, RF_WD3, e.a, e.d);
               end
            end
         end
         if (DBG_RVALID) begin
            total++;
            if (rq.size() == 0) begin
               bad++;
               $display("FAIL rvalid_unexpected: got rdata=%h, no read pending", DBG_RDATA);
            end else begin
               logic [31:0] r;
               r = rq.pop_front();
               if (r != DBG_RDATA) begin
                  bad++;
                  $display("FAIL rdata: got %h, required %h", DBG_RDATA, r);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic push_init(input int n);
      for (int i = 0; i < n; i++) begin
         wr_t e;
         e.a = 5'(i);
         e.d = 32'd0;
         wq.push_back(e);
      end
   endtask

   task automatic push_wr(input logic [4:0] a, input logic [31:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      wq.push_back(e);
   endtask

   task automatic dbg_req(input logic we, input logic [4:0] a, input logic [31:0] d);
      int n = 0;
      while (!DBG_READY && n < 20) begin
         step();
         n++;
      end
      chk("dbg_ready_wait", {31'd0, DBG_READY}, 32'd1);
      DBG_VALID = 1'b1;
      DBG_WE    = we;
      DBG_ADDR  = a;
      DBG_WDATA = d;
      step();
      DBG_VALID = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_init_done"}, {31'd0, INIT_DONE}, 32'd0);
      chk({tag, "_dbg_ready"}, {31'd0, DBG_READY}, 32'd0);
      chk({tag, "_rvalid"},    {31'd0, DBG_RVALID}, 32'd0);
      chk({tag, "_rdata"},     DBG_RDATA, 32'd0);
      chk({tag, "_stall"},     {31'd0, CORE_STALL}, 32'd1);
      chk({tag, "_we3"},       {31'd0, RF_WE3}, 32'd1);
      chk({tag, "_a3"},        {27'd0, RF_A3}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      RST_N = 1'b0;
      WB_EN = 1'b0; WB_ADDR = '0; WB_DATA = '0; CORE_A1 = '0;
      DBG_VALID = 1'b0; DBG_WE = 1'b0; DBG_ADDR = '0; DBG_WDATA = '0;
      step();
      preload = 1'b0;
      step();
      chk_reset_vals("rst");

      // init clear: addresses 0..31, done after 32 edges
      push_init(32);
      RST_N = 1'b1;
      repeat (31) step();
      chk("init_done_early", {31'd0, INIT_DONE}, 32'd0);
      chk("init_last_a3", {27'd0, RF_A3}, 32'd31);
      step();
      chk("init_done", {31'd0, INIT_DONE}, 32'd1);
      chk("run_stall", {31'd0, CORE_STALL}, 32'd0);
      CORE_A1 = 5'd12;
      #1;
      chk("a1_follow", {27'd0, RF_A1}, 32'd12);

      // idle debug write
      push_wr(5'd5, 32'd15);
      dbg_req(1'b1, 5'd5, 32'd15);
      chk("idle_wr_ready_low", {31'd0, DBG_READY}, 32'd0);
      step();
      chk("idle_wr_ready_back", {31'd0, DBG_READY}, 32'd1);

      // starvation: core hammers addr 7 while debug writes 0xAA there
      WB_EN = 1'b1; WB_ADDR = 5'd7; WB_DATA = 32'h70;
      DBG_VALID = 1'b1; DBG_WE = 1'b1; DBG_ADDR = 5'd7; DBG_WDATA = 32'hAA;
      push_wr(5'd7, 32'h70);
      step();
      DBG_VALID = 1'b0;
      for (int k = 0; k < 4; k++) begin
         push_wr(5'd7, 32'h70);
         chk("starve_no_stall", {31'd0, CORE_STALL}, 32'd0);
         step();
      end
      push_wr(5'd7, 32'hAA);
      chk("starve_stall", {31'd0, CORE_STALL}, 32'd1);
      step();
      WB_EN = 1'b0;
      chk("starve_released", {31'd0, CORE_STALL}, 32'd0);

      // debug read of register 5; core write attempted during the issue cycle
      rq.push_back(32'd15);
      dbg_req(1'b0, 5'd5, 32'd0);
      WB_EN = 1'b1; WB_ADDR = 5'd9; WB_DATA = 32'h99;
      #1;
      chk("rd_issue_stall", {31'd0, CORE_STALL}, 32'd1);
      chk("rd_issue_a1", {27'd0, RF_A1}, 32'd5);
      chk("rd_issue_we3", {31'd0, RF_WE3}, 32'd0);
      chk("rd_issue_ready", {31'd0, DBG_READY}, 32'd0);
      step();
      WB_EN = 1'b0;
      chk("rd_rvalid", {31'd0, DBG_RVALID}, 32'd1);
      chk("rd_ready_in_rvalid", {31'd0, DBG_READY}, 32'd1);
      chk("rd_a1_restored", {27'd0, RF_A1}, 32'd12);
      step();
      chk("rd_rvalid_pulse", {31'd0, DBG_RVALID}, 32'd0);

      // back-to-back write then read of the same register
      push_wr(5'd3, 32'h33);
      dbg_req(1'b1, 5'd3, 32'h33);
      chk("b2b_ready_low", {31'd0, DBG_READY}, 32'd0);
      rq.push_back(32'h33);
      dbg_req(1'b0, 5'd3, 32'd0);
      step();
      rq.push_back(32'hAA);
      dbg_req(1'b0, 5'd7, 32'd0);
      step();
      rq.push_back(32'd0);
      dbg_req(1'b0, 5'd9, 32'd0);
      step();

      // reset during the read-issue cycle: no response may appear
      dbg_req(1'b0, 5'd5, 32'd0);
      #1;
      RST_N = 1'b0;
      #1;
      chk_reset_vals("rst_rd");
      step();
      step();

      // reset again at init count 10
      push_init(10);
      RST_N = 1'b1;
      repeat (10) step();
      chk("mid_init_a3", {27'd0, RF_A3}, 32'd10);
      chk("mid_init_done", {31'd0, INIT_DONE}, 32'd0);
      #1;
      RST_N = 1'b0;
      #1;
      chk_reset_vals("rst_init");
      step();
      push_init(32);
      RST_N = 1'b1;
      repeat (32) step();
      chk("reinit_done", {31'd0, INIT_DONE}, 32'd1);
      rq.push_back(32'd0);
      dbg_req(1'b0, 5'd5, 32'd0);
      step();
      step();

      chk("wq_empty", wq.size(), 32'd0);
      chk("rq_empty", rq.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
